// File: rtl/axis_pixels_shift_pkg.sv
// Shared types and geometry for the pixel-shift unroller that feeds the
// depthwise conv engine.
package axis_pixels_shift_pkg;

  localparam int UNITS         = 4;
  localparam int WORD_WIDTH    = 8;
  localparam int IM_SHIFT_REGS = 6;
  localparam int BITS_IM_SHIFT = 2;
  localparam int TUSER_WIDTH   = 3;
  localparam int MAX_SHIFT     = IM_SHIFT_REGS - UNITS;

  typedef logic [WORD_WIDTH-1:0]               word_t;
  typedef logic [BITS_IM_SHIFT-1:0]            shift_t;
  typedef logic [TUSER_WIDTH-1:0]              user_t;
  typedef logic [IM_SHIFT_REGS*WORD_WIDTH-1:0] in_words_t;
  typedef logic [UNITS*WORD_WIDTH-1:0]         out_words_t;

endpackage

// File: rtl/axis_pixels_shift_if.sv
// Input (wide beat + shift) and output (window sub-beat) streams of the
// pixel-shift unroller, bundled as one interface.
interface axis_pixels_shift_if;
  import axis_pixels_shift_pkg::*;

  logic       s_ready;
  logic       s_valid;
  in_words_t  s_data;
  shift_t     s_shift;
  logic       s_ones;
  user_t      s_user;

  logic       m_ready;
  logic       m_valid;
  out_words_t m_data;
  logic       m_ones;
  user_t      m_user;
  shift_t     m_index;
  logic       m_last;

  modport slave (
    output s_ready,
    input  s_valid, s_data, s_shift, s_ones, s_user,
    input  m_ready,
    output m_valid, m_data, m_ones, m_user, m_index, m_last
  );

  modport master (
    input  s_ready,
    output s_valid, s_data, s_shift, s_ones, s_user,
    output m_ready,
    input  m_valid, m_data, m_ones, m_user, m_index, m_last
  );

endinterface

// File: rtl/axis_pixels_shift_pixel_window_mux.sv
// Selects UNITS consecutive words starting at word 'index' of the held beat.
module pixel_window_mux
  import axis_pixels_shift_pkg::*;
(
  input  in_words_t  words,
  input  shift_t     index,
  output out_words_t window
);

  // Constant-indexed compare/select keeps every word access in range.
  always_comb begin
    window = '0;
    for (int k = 0; k < UNITS; k++) begin
      for (int j = 0; j < IM_SHIFT_REGS; j++) begin
        if (j == int'(index) + k)
          window[k*WORD_WIDTH +: WORD_WIDTH] = words[j*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

endmodule

// File: rtl/register.sv
// Generic clock-enabled register with synchronous active-low reset.
module register #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clock_enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rstn)             q <= RESET_VALUE;
    else if (clock_enable) q <= d;
  end

endmodule

// File: rtl/axis_pixels_shift.sv
// Unrolls each wide pixel beat into (shift+1) UNITS-word window beats;
// ones/preamble beats pass through as a single beat.
module axis_pixels_shift
  import axis_pixels_shift_pkg::*;
(
  input  logic               aclk,
  input  logic               aresetn,
  axis_pixels_shift_if.slave axis
);

  function automatic shift_t sat_shift(input logic ones, input shift_t sh);
    if (ones) return '0;
    if (sh > shift_t'(MAX_SHIFT)) return shift_t'(MAX_SHIFT);
    return sh;
  endfunction

  localparam int LOAD_W = IM_SHIFT_REGS*WORD_WIDTH + BITS_IM_SHIFT + 1 + TUSER_WIDTH;

  logic      vld_p1;
  shift_t    index_p1;
  in_words_t data_p1;
  shift_t    shift_p1;
  logic      ones_p1;
  user_t     user_p1;

  logic      s_beat, m_beat, last_p1;
  logic      vld_d;
  shift_t    index_d;

  // p0 -> p1: accept a wide beat into the holding register
  assign last_p1      = (index_p1 == shift_p1);
  assign m_beat       = vld_p1 & axis.m_ready;
  assign axis.s_ready = !vld_p1 | (m_beat & last_p1);
  assign s_beat       = axis.s_valid & axis.s_ready;

  always_comb begin
    vld_d   = vld_p1;
    index_d = index_p1;
    if (m_beat) begin
      if (last_p1) begin
        vld_d   = 1'b0;
        index_d = '0;
      end else begin
        index_d = index_p1 + 1'b1;
      end
    end
    // A reload on the final sub-beat takes priority so groups chain without a bubble.
    if (s_beat) begin
      vld_d   = 1'b1;
      index_d = '0;
    end
  end

  register #(.WIDTH(1)) u_vld (
    .clk(aclk), .rstn(aresetn), .clock_enable(1'b1), .d(vld_d), .q(vld_p1)
  );

  register #(.WIDTH(BITS_IM_SHIFT)) u_index (
    .clk(aclk), .rstn(aresetn), .clock_enable(s_beat | m_beat), .d(index_d), .q(index_p1)
  );

  register #(.WIDTH(LOAD_W)) u_load (
    .clk          (aclk),
    .rstn         (aresetn),
    .clock_enable (s_beat),
    .d            ({axis.s_data, sat_shift(axis.s_ones, axis.s_shift), axis.s_ones, axis.s_user}),
    .q            ({data_p1, shift_p1, ones_p1, user_p1})
  );

  // p1 -> out: window select from the held beat
  pixel_window_mux u_mux (
    .words  (data_p1),
    .index  (index_p1),
    .window (axis.m_data)
  );

  assign axis.m_valid = vld_p1;
  assign axis.m_ones  = ones_p1;
  assign axis.m_user  = user_p1;
  assign axis.m_index = index_p1;
  assign axis.m_last  = last_p1;

endmodule

// File: tb/tb_axis_pixels_shift.sv
// Scoreboarded directed bench for the pixel-shift unroller.
module tb_axis_pixels_shift;
  import axis_pixels_shift_pkg::*;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axis_pixels_shift_if bus ();

  axis_pixels_shift dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .axis    (bus)
  );

  typedef struct packed {
    out_words_t data;
    logic       ones;
    user_t      user;
    shift_t     idx;
    logic       last;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  localparam in_words_t W = 48'h05_04_03_02_01_00;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted output beat and checks holds on stalls.
  logic       stall = 1'b0;
  out_words_t hd;
  user_t      hu;
  shift_t     hi;
  logic       ho;

  always @(negedge aclk) begin
    if (aresetn && stall) begin
      chk("hold_valid", bus.m_valid, 1'b1);
      chk("hold_data", bus.m_data, hd);
      chk("hold_index", bus.m_index, hi);
      chk("hold_user", bus.m_user, hu);
      chk("hold_ones", bus.m_ones, ho);
    end
    stall <= aresetn && bus.m_valid && !bus.m_ready;
    hd <= bus.m_data;
    hu <= bus.m_user;
    hi <= bus.m_index;
    ho <= bus.m_ones;
    if (aresetn && bus.m_valid && bus.m_ready) begin
      total++;
      assert (q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_beat observed=%0h expected=none", bus.m_data);
      end
      if (q.size() != 0) begin
        chk("beat_data", bus.m_data, q[0].data);
        chk("beat_ones", bus.m_ones, q[0].ones);
        chk("beat_user", bus.m_user, q[0].user);
        chk("beat_index", bus.m_index, q[0].idx);
        chk("beat_last", bus.m_last, q[0].last);
        q.delete(0);
      end
    end
  end

  task automatic send(input in_words_t d, input shift_t sh, input logic on,
                      input user_t u, output int waits);
    logic ok;
    int eff;
    exp_t e;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_shift = sh;
    bus.s_ones  = on;
    bus.s_user  = u;
    waits = 0;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge aclk);
      if (bus.s_ready) ok = 1'b1;
      else waits++;
    end
    total++;
    assert (ok) else begin
      bad++;
      $error("FAIL send_timeout observed=%0d expected=accept", waits);
    end
    if (ok) begin
      eff = on ? 0 : ((int'(sh) > MAX_SHIFT) ? MAX_SHIFT : int'(sh));
      for (int i = 0; i <= eff; i++) begin
        e.data = d[i*WORD_WIDTH +: UNITS*WORD_WIDTH];
        e.ones = on;
        e.user = u;
        e.idx  = shift_t'(i);
        e.last = (i == eff);
        q.push_back(e);
      end
    end
    @(posedge aclk);
    #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    for (int n = 0; n < 200 && (q.size() != 0 || bus.m_valid); n++) begin
      if (rnd) bus.m_ready = 1'($urandom_range(0, 1));
      @(posedge aclk);
      #1;
    end
    bus.m_ready = 1'b1;
    total++;
    assert (q.size() == 0 && !bus.m_valid) else begin
      bad++;
      $error("FAIL drain observed=%0d expected=0 pending", q.size());
    end
  endtask

  initial begin
    int w;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_shift = '0;
    bus.s_ones  = 1'b0;
    bus.s_user  = '0;
    bus.m_ready = 1'b1;

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_m_valid", bus.m_valid, 1'b0);
    chk("rst_m_index", bus.m_index, '0);
    chk("rst_m_data", bus.m_data, '0);
    chk("rst_m_user", bus.m_user, '0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    chk("rst_s_ready", bus.s_ready, 1'b1);
    @(posedge aclk);
    #1;

    // shift=2, free-flowing output
    send(W, 2'd2, 1'b0, 3'b101, w);
    @(negedge aclk);
    chk("s2_ready0", bus.s_ready, 1'b0);
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("s2_ready1", bus.s_ready, 1'b0);
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("s2_ready2", bus.s_ready, 1'b1);
    @(posedge aclk); #1;
    drain(1'b0);

    // shift=0 back-to-back beats
    send(W, 2'd0, 1'b0, 3'b001, w);
    chk("b2b_wait0", w, 0);
    send(W >> 8, 2'd0, 1'b0, 3'b010, w);
    chk("b2b_wait1", w, 0);
    send(W >> 16, 2'd0, 1'b0, 3'b100, w);
    chk("b2b_wait2", w, 0);
    drain(1'b0);

    // ones beat ignores shift
    send(48'h1, 2'd2, 1'b1, 3'b010, w);
    drain(1'b0);

    // output stalls mid-group
    bus.m_ready = 1'b0;
    send(W, 2'd2, 1'b0, 3'b110, w);
    repeat (2) begin
      @(posedge aclk);
      #1;
    end
    drain(1'b1);

    // shift beyond the maximum saturates
    send(W, 2'd3, 1'b0, 3'b001, w);
    drain(1'b0);

    // reset in the middle of a group
    send(W, 2'd2, 1'b0, 3'b011, w);
    @(posedge aclk);
    #1;
    chk("mid_index", bus.m_index, 2'd1);
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    q.delete();
    aresetn = 1'b1;
    @(negedge aclk);
    chk("post_rst_valid", bus.m_valid, 1'b0);
    chk("post_rst_ready", bus.s_ready, 1'b1);
    @(posedge aclk);
    #1;
    send(W, 2'd1, 1'b0, 3'b111, w);
    drain(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
